// File: rtl/unidade_store.sv
// Store-side data path: narrows a register value to byte/half/word lanes and
// drives a single-outstanding write handshake to data memory with a wait-state timeout.
module unidade_store #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [1:0]  tamanho,
  input  logic [31:0] endereco,
  input  logic [31:0] dado,
  output logic        pronto,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        concluido,
  output logic        erro_alinhamento,
  output logic        erro_timeout
);

  typedef enum logic [1:0] {IDLE, ESCRITA, FIM, ERRO} estado_t;

  estado_t            estado_q, estado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pronto_q, pronto_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_be_q, mem_be_d;
  logic               concluido_q, concluido_d;
  logic               erro_alinhamento_q, erro_alinhamento_d;
  logic               erro_timeout_q, erro_timeout_d;
  logic               desalinhado;

  // Size code 11 is reserved and reported as a misaligned store.
  always_comb begin
    desalinhado = 1'b0;
    case (tamanho)
      2'b00:   desalinhado = 1'b0;
      2'b01:   desalinhado = endereco[0];
      2'b10:   desalinhado = |endereco[1:0];
      default: desalinhado = 1'b1;
    endcase
  end

  always_comb begin
    estado_d           = estado_q;
    cnt_d              = cnt_q;
    pronto_d           = pronto_q;
    mem_we_d           = mem_we_q;
    mem_addr_d         = mem_addr_q;
    mem_wdata_d        = mem_wdata_q;
    mem_be_d           = mem_be_q;
    concluido_d        = 1'b0;
    erro_alinhamento_d = 1'b0;
    erro_timeout_d     = 1'b0;

    case (estado_q)
      IDLE: begin
        pronto_d = 1'b1;
        if (inicio) begin
          pronto_d = 1'b0;
          if (desalinhado) begin
            estado_d           = ERRO;
            erro_alinhamento_d = 1'b1;
          end else begin
            estado_d   = ESCRITA;
            cnt_d      = '0;
            mem_we_d   = 1'b1;
            mem_addr_d = {endereco[31:2], 2'b00};
            case (tamanho)
              2'b00: begin
                mem_wdata_d = {4{dado[7:0]}};
                mem_be_d    = 4'b0001 << endereco[1:0];
              end
              2'b01: begin
                mem_wdata_d = {2{dado[15:0]}};
                mem_be_d    = endereco[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                mem_wdata_d = dado;
                mem_be_d    = 4'b1111;
              end
            endcase
          end
        end
      end

      // An ack on the last allowed wait cycle still counts as success.
      ESCRITA: begin
        if (mem_ack) begin
          estado_d    = FIM;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b0000;
          concluido_d = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          estado_d       = FIM;
          mem_we_d       = 1'b0;
          mem_be_d       = 4'b0000;
          erro_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIM: begin
        estado_d = IDLE;
        pronto_d = 1'b1;
      end

      default: begin
        estado_d = IDLE;
        pronto_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q           <= IDLE;
      cnt_q              <= '0;
      pronto_q           <= 1'b1;
      mem_we_q           <= 1'b0;
      mem_addr_q         <= '0;
      mem_wdata_q        <= '0;
      mem_be_q           <= '0;
      concluido_q        <= 1'b0;
      erro_alinhamento_q <= 1'b0;
      erro_timeout_q     <= 1'b0;
    end else begin
      estado_q           <= estado_d;
      cnt_q              <= cnt_d;
      pronto_q           <= pronto_d;
      mem_we_q           <= mem_we_d;
      mem_addr_q         <= mem_addr_d;
      mem_wdata_q        <= mem_wdata_d;
      mem_be_q           <= mem_be_d;
      concluido_q        <= concluido_d;
      erro_alinhamento_q <= erro_alinhamento_d;
      erro_timeout_q     <= erro_timeout_d;
    end
  end

  assign pronto           = pronto_q;
  assign mem_we           = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_be           = mem_be_q;
  assign concluido        = concluido_q;
  assign erro_alinhamento = erro_alinhamento_q;
  assign erro_timeout     = erro_timeout_q;

endmodule
